// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, the NOP word and the reset PC.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic is_misaligned(
    input logic [31:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the fetch unit: JALR > branch/JAL > PC+4.
// Ports: PC, PCsrc, reg_jump, ImmExt, ALUResult in; next_pc, misaligned out.
import fetch_pkg::*;

module next_pc_sel (
  input  logic [31:0] PC,
  input  logic        PCsrc,
  input  logic        reg_jump,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = PC + 32'd4;
    priority case (1'b1)
      reg_jump: next_pc = ALUResult & 32'hFFFF_FFFE;
      PCsrc:    next_pc = PC + ImmExt;
      default:  next_pc = PC + 32'd4;
    endcase
  end

  assign misaligned = is_misaligned(next_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC, fetches from variable-latency imem,
// hands instructions to decode with valid/ready, follows branch/JALR.
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_valid/
// imem_rdata to memory; Instr/PC/PCPlus4/instr_valid/instr_ready to
// decode; PCsrc/reg_jump/ImmExt/ALUResult from control; fetch_fault.
import fetch_pkg::*;

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 64,
  parameter int          TO_W     = 7
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCsrc,
  input  logic        reg_jump,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        fetch_fault
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  fetch_state_t    state;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     next_pc;
  logic            misaligned;

  next_pc_sel u_next_pc_sel (
    .PC        (PC),
    .PCsrc     (PCsrc),
    .reg_jump  (reg_jump),
    .ImmExt    (ImmExt),
    .ALUResult (ALUResult),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  assign imem_addr = PC;
  assign PCPlus4   = PC + 32'd4;

  // imem_req is registered: it is raised on every edge that
  // enters S_REQ and dropped on the edge that leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      PC          <= RESET_PC;
      Instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      to_cnt      <= '0;
      imem_req    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          state    <= S_WAIT;
          imem_req <= 1'b0;
          to_cnt   <= '0;
        end
        S_WAIT: begin
          if (imem_valid) begin
            Instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_VALID;
          end else if (to_cnt == TO_LAST) begin
            fetch_fault <= 1'b1;
            state       <= S_FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_VALID: begin
          // Control inputs are only meaningful in the handshake cycle.
          if (instr_ready) begin
            instr_valid <= 1'b0;
            PC          <= next_pc;
            if (misaligned) begin
              fetch_fault <= 1'b1;
              state       <= S_FAULT;
            end else begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// randomized fetch streams against a transaction-level PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCsrc = 1'b0;
  logic        reg_jump = 1'b0;
  logic [31:0] ImmExt = '0;
  logic [31:0] ALUResult = '0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(RPC),
    .TIMEOUT (TMO),
    .TO_W    (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .PCsrc      (PCsrc),
    .reg_jump   (reg_jump),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .fetch_fault(fetch_fault)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic junk;
    PCsrc     = 1'($urandom);
    reg_jump  = 1'($urandom);
    ImmExt    = $urandom;
    ALUResult = $urandom;
  endtask

  task automatic do_reset;
    rst         = 1'b1;
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
    junk();
    tick();
    tick();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_pc", PC, RPC);
    chk("rst_instr", Instr, 32'h0000_0013);
    rst    = 1'b0;
    exp_pc = RPC;
  endtask

  // One full fetch transaction: request, L-cycle response, optional
  // stall, then handshake with the given control-flow decision.
  task automatic fetch_one(input int lat, input int hold,
                           input bit src, input bit rj,
                           input logic [31:0] imm,
                           input logic [31:0] alu,
                           input logic [31:0] data,
                           input int exp_wait,
                           output bit faulted);
    int          n;
    logic [31:0] nxt;
    faulted = 1'b0;
    n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    chk("req_gap", 32'(n), 32'(exp_wait));
    chk("req_addr", imem_addr, exp_pc);
    for (int i = 1; i <= lat; i++) begin
      junk();
      tick();
      chk("inflight_req", 32'(imem_req), 0);
      chk("inflight_vld", 32'(instr_valid), 0);
    end
    imem_valid = 1'b1;
    imem_rdata = data;
    tick();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    chk("resp_vld", 32'(instr_valid), 1);
    chk("resp_instr", Instr, data);
    chk("resp_pc", PC, exp_pc);
    chk("resp_pc4", PCPlus4, exp_pc + 32'd4);
    instr_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      imem_valid = 1'(i);
      imem_rdata = $urandom;
      junk();
      tick();
      chk("hold_instr", Instr, data);
      chk("hold_pc", PC, exp_pc);
      chk("hold_req", 32'(imem_req), 0);
      chk("hold_vld", 32'(instr_valid), 1);
    end
    imem_valid  = 1'b0;
    instr_ready = 1'b1;
    PCsrc       = src;
    reg_jump    = rj;
    ImmExt      = imm;
    ALUResult   = alu;
    if (rj)
      nxt = {alu[31:1], 1'b0};
    else if (src)
      nxt = exp_pc + imm;
    else
      nxt = exp_pc + 32'd4;
    tick();
    instr_ready = 1'b0;
    junk();
    chk("acc_pc", PC, nxt);
    chk("acc_vld", 32'(instr_valid), 0);
    if (nxt[1:0] != 2'b00) begin
      faulted = 1'b1;
      chk("mis_fault", 32'(fetch_fault), 1);
      chk("mis_req", 32'(imem_req), 0);
    end else begin
      chk("acc_fault", 32'(fetch_fault), 0);
      chk("acc_req", 32'(imem_req), 1);
    end
    exp_pc = nxt;
  endtask

  initial begin
    bit          f;
    int          c;
    int          lat;
    int          hold;
    int          kind;
    int          ew;
    bit          src;
    bit          rj;
    logic [31:0] imm;
    logic [31:0] alu;

    do_reset();
    fetch_one(1, 0, 0, 0, 0, 0, 32'h0050_0093, 1, f);
    fetch_one(3, 0, 0, 0, 0, 0, $urandom, 0, f);
    fetch_one(3, 0, 1, 0, 32'hFFFF_FFF8, 0, $urandom, 0, f);
    chk("br_target", exp_pc, 0);
    fetch_one(3, 0, 1, 1, 32'h40, 32'h101, $urandom, 0, f);
    chk("jalr_fault", 32'(f), 0);
    fetch_one(2, 10, 0, 0, 0, 0, $urandom, 0, f);
    fetch_one(2, 0, 0, 1, 0, 32'hFFFF_FFFC, $urandom, 0, f);
    fetch_one(1, 0, 0, 0, 0, 0, $urandom, 0, f);
    for (int k = 0; k < 4; k++)
      fetch_one(3, 0, 0, 0, 0, 0, $urandom, 0, f);

    // Timeout: request goes unanswered.
    do_reset();
    c = 0;
    while (!imem_req && c < 8) begin
      tick();
      c++;
    end
    chk("to_req", 32'(imem_req), 1);
    c = 0;
    while (!fetch_fault && c < TMO + 8) begin
      tick();
      c++;
    end
    chk("to_cycles", 32'(c), 32'(TMO + 1));
    for (int k = 0; k < 5; k++) begin
      imem_valid = 1'(k);
      tick();
      chk("to_sticky", 32'(fetch_fault), 1);
      chk("to_noreq", 32'(imem_req), 0);
      chk("to_novld", 32'(instr_valid), 0);
    end
    imem_valid = 1'b0;

    // Misaligned branch target.
    do_reset();
    fetch_one(1, 0, 1, 0, 32'd2, 0, $urandom, 1, f);
    chk("mis_flag", 32'(f), 1);
    chk("mis_pc", PC, RPC + 32'd2);
    repeat (4) tick();
    chk("mis_sticky", 32'(fetch_fault), 1);
    chk("mis_noreq", 32'(imem_req), 0);

    // Reset during S_WAIT, stale response in S_IDLE.
    do_reset();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    chk("stale_instr", Instr, 32'h0000_0013);
    chk("stale_vld", 32'(instr_valid), 0);
    exp_pc = RPC;
    fetch_one(2, 0, 0, 0, 0, 0, 32'h1234_5673, 0, f);
    chk("stale_never", 32'(Instr == 32'hDEAD_BEEF), 0);

    // Randomized streams.
    do_reset();
    ew = 1;
    for (int k = 0; k < 60; k++) begin
      lat  = $urandom_range(1, 6);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      kind = $urandom_range(0, 9);
      src  = 1'b0;
      rj   = 1'b0;
      imm  = $urandom;
      alu  = $urandom;
      if (kind >= 6 && kind <= 7) begin
        src = 1'b1;
        imm = 32'($urandom_range(0, 64)) - 32'd32;
        imm = imm << 2;
        if ($urandom_range(0, 7) == 0)
          imm = imm + 32'd2;
      end else if (kind >= 8) begin
        rj  = 1'b1;
        src = 1'($urandom);
        if ($urandom_range(0, 3) != 0)
          alu[1] = 1'b0;
      end
      fetch_one(lat, hold, src, rj, imm, alu, $urandom, ew, f);
      if (f) begin
        do_reset();
        ew = 1;
      end else begin
        ew = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Produces the 32-bit instruction stream that the control decoder consumes, and consumes that decoder's PCsrc/reg_jump outputs to choose the next PC.
- Owns the PC register and runs a request/response handshake with instruction memory, which has a variable latency.
- Presents each fetched instruction with a valid/ready handshake to the decode stage.
- Sits between instruction memory and control/datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT, 64, maximum cycles in S_WAIT before a fetch fault.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; single clock domain, reset is synchronous and active-high.
- imem_req  out  1  request strobe, high for exactly one cycle per fetch.
- imem_addr  out  32  fetch address, always equal to PC.
- imem_valid  in  1  response strobe; rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- Instr  out  32  registered instruction to control/datapath.
- PC  out  32  address of the presented Instr.
- PCPlus4  out  32  PC+4, for JAL/JALR link.
- instr_valid  out  1  Instr/PC are valid.
- instr_ready  in  1  decode accepts this cycle.
- PCsrc  in  1  taken branch/JAL for the presented Instr.
- reg_jump  in  1  JALR for the presented Instr.
- ImmExt  in  32  sign-extended offset for branch/JAL.
- ALUResult  in  32  rs1+imm, the JALR target.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- Reset values (registered on the rst edge):
  - state=S_IDLE, PC=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, fetch_fault=0, timeout counter=0.
  - imem_req=0 while state is S_IDLE.
- States: S_IDLE, S_REQ, S_WAIT, S_VALID, S_FAULT.
- S_IDLE: next cycle with rst=0 go to S_REQ.
- S_REQ:
  - imem_req=1, imem_addr=PC.
  - Go to S_WAIT unconditionally and clear the counter.
- S_WAIT:
  - On imem_valid: Instr<=imem_rdata, instr_valid<=1, go to S_VALID.
  - Otherwise increment the counter. When counter==TIMEOUT-1 with no response, set fetch_fault and go to S_FAULT.
- S_VALID:
  - Hold Instr/PC stable while instr_ready=0.
  - On instr_ready=1: instr_valid<=0, PC<=next_pc, go to S_REQ.
- next_pc, sampled only in the handshake cycle:
  - reg_jump=1: {ALUResult[31:1],1'b0}. reg_jump has priority over PCsrc.
  - else PCsrc=1: PC+ImmExt, modulo 2^32.
  - else PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Misaligned target: if next_pc[1:0]!=0, PC still loads next_pc, fetch_fault<=1, and state goes to S_FAULT instead of S_REQ.
- S_FAULT:
  - imem_req=0, instr_valid=0.
  - Remains until rst. fetch_fault stays high until rst.
- imem_valid outside S_WAIT is ignored; no state or data change.
- Memory guarantees latency ≥1: a response never arrives in the same cycle as the request.
- Latency: request in cycle t, response in t+L, instr_valid high from t+L+1, next request the cycle after acceptance. Peak throughput is one instruction per L+2 cycles.
- Reset mid-operation:
  - rst in any state returns all registers to reset values on that edge.
  - Instruction memory shares rst and drops the outstanding response; any stale imem_valid arrives in S_IDLE/S_REQ and is ignored.
- PCPlus4 is combinational PC+4.
- PCsrc/reg_jump/ImmExt/ALUResult may be X outside the S_VALID handshake cycle; this must not affect state.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum (S_IDLE, S_REQ, S_WAIT, S_VALID, S_FAULT).
  - NOP_INSTR=32'h0000_0013.
  - RESET_PC_DEFAULT.
- One combinational sub-module, next_pc_sel: inputs PC, PCsrc, reg_jump, ImmExt, ALUResult; outputs next_pc and misaligned.

Test Plan:
- Reset then L=1 memory returning 32'h00500093 -> imem_req in the cycle after rst falls, addr 0. instr_valid two cycles later with Instr=32'h00500093, PC=0, PCPlus4=4.
- Sequential fetch, instr_ready always 1, L=3 -> addresses 0, 4, 8, 12; each request 5 cycles apart; instr_valid one cycle per fetch.
- At PC=8 accept with PCsrc=1, ImmExt=32'hFFFF_FFF8 -> next imem_addr=0. With reg_jump=1, PCsrc=1, ALUResult=32'h101 -> next addr 32'h100, no fault.
- Hold instr_ready=0 for 10 cycles in S_VALID with imem_valid pulsed -> Instr/PC unchanged, no new request. Release -> a single request follows.
- No imem_valid for TIMEOUT cycles -> fetch_fault=1, imem_req stays 0, the state persists, and rst clears it. Separately, PCsrc=1 with ImmExt=2 -> fetch_fault=1 and PC=RESET_PC+2.
- rst asserted in S_WAIT, then a stale imem_valid with 32'hDEADBEEF in the S_IDLE cycle -> ignored. The fresh fetch is from RESET_PC, and Instr is never 32'hDEADBEEF.
